data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory interface: accepts word-addressed reads and byte-strobed writes from the multicycle CPU and returns registered read data.
- Holds a byte-writable RAM plus a small MMIO window: cycle counter, store counter, scratch register, and a TOHOST termination register that raises sim_done.
- Sits between the CPU's data port and the testbench/top level.

Parameters:
- ADDR_WIDTH, 14, word-index width of the RAM (2^14 words = 64 KiB, byte addresses 0x0000_0000..0x0000_FFFF).
- MMIO_BASE, 32'hFFFF_0000, byte base address of the MMIO window (16 bytes, 4 word registers).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- data_read  input  1  read enable; the CPU holds it at 1.
- data_write  input  4  byte write strobes; bit k writes data_in[8k+7:8k]; 0 = no write.
- data_addr  input  32  byte address; bits [1:0] are ignored for indexing.
- data_in  input  32  write data.
- data_out  output  32  registered read data.
- sim_done  output  1  sticky; set by any write to TOHOST.
- done_code  output  32  value latched from the TOHOST write.
- addr_err  output  1  sticky; set by an access (read with data_read=1, or write) outside RAM and outside the MMIO window.

Behaviour:
- Reset (rst=1 at a clock edge): data_out=0, sim_done=0, done_code=0, addr_err=0, CYCLE=0, STORE_CNT=0, SCRATCH=0. RAM contents are not reset (testbench preloads them).
- Decode:
  - RAM hit when data_addr[31:ADDR_WIDTH+2]==0.
  - MMIO hit when data_addr[31:4]==MMIO_BASE[31:4].
  - Anything else is out of range.
- Read: latency 1.
  - If data_read=1 at edge N, data_out after edge N = contents at data_addr sampled at edge N.
  - If data_read=0, data_out holds its value.
  - Out-of-range reads return 0.
- Write: any edge with data_write!=0 performs the write; each byte updates only where its strobe bit is 1.
- Read-during-write to the same word at the same edge is read-first: data_out returns the pre-write contents.
- MMIO map (offset = data_addr[3:2]):
  - 0 CYCLE: RO. Increments every cycle after reset, wraps at 2^32. Writes are ignored.
  - 1 STORE_CNT: RO. Increments by 1 for each edge with an accepted RAM write (data_write!=0, RAM hit, sim_done=0). Wraps. Writes are ignored.
  - 2 TOHOST: write sets sim_done=1 and done_code = strobed bytes of data_in merged over 0. A read returns done_code.
  - 3 SCRATCH: RW with byte strobes.
- After sim_done=1:
  - RAM and SCRATCH writes are ignored.
  - Further TOHOST writes are ignored; done_code is frozen.
  - Reads still work and CYCLE keeps counting.
- Out-of-range write: no state change except addr_err=1. addr_err clears only on rst.
- A read of CYCLE returns the value before that edge's increment.
- A reset in the middle of an access wins: no write occurs on an edge where rst=1.

Decomposition:
- Package data_mem_pkg:
  - Default MMIO_BASE.
  - Offset constants MMIO_CYCLE=2'd0, MMIO_STORE_CNT=2'd1, MMIO_TOHOST=2'd2, MMIO_SCRATCH=2'd3.
  - Strobe constant WSTRB_WORD=4'hf.
- Sub-module bytewrite_sram: parameter ADDR_WIDTH; ports clk, we[3:0], addr, wdata, rdata. Read-first, registered read, no reset.
- Decode, MMIO registers, counters and sticky flags live in data_mem_responder.

Test Plan:
- Reset, then addr=0x0000_0010, write=4'hf, din=0xDEADBEEF; next cycle read 0x10 -> data_out=0xDEADBEEF one cycle after the read address; STORE_CNT reads 1.
- Byte strobes: word 0x20 = 0x11223344, write=4'b0101 with din=0xAABBCCDD -> readback 0x11BB33DD.
- Same-edge read/write to 0x30 (old 0x0, new 0x5) -> data_out=0x0 that cycle; the next read returns 0x5.
- Write 0x0000_002A to 0xFFFF_0008 -> sim_done=1, done_code=0x2A. A subsequent write of 0x99 to 0x40 is ignored: 0x40 reads its old value and STORE_CNT is unchanged.
- Write to 0x8000_0000 -> addr_err=1 and no other state change; a read there gives data_out=0. Asserting rst clears addr_err, sim_done and counters to 0.
- Read CYCLE at 0xFFFF_0000 exactly 10 edges after reset deasserts -> returns 9. Read of SCRATCH after writing 0xCAFE0000 with strobe 4'b1100 -> 0xCAFE0000.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared constants and helpers for the CPU data-memory responder.
package data_mem_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

  localparam logic [1:0] MMIO_CYCLE     = 2'd0;
  localparam logic [1:0] MMIO_STORE_CNT = 2'd1;
  localparam logic [1:0] MMIO_TOHOST    = 2'd2;
  localparam logic [1:0] MMIO_SCRATCH   = 2'd3;

  localparam logic [3:0] WSTRB_WORD = 4'hf;

  // Byte-lane merge: lanes with a set strobe take new_val, others keep old_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) begin
        res[8*k +: 8] = new_val[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_val[8*k +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/data_mem_responder_bytewrite_sram.sv
// Byte-writable single-port RAM, read-first with a registered read port.
module bytewrite_sram #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [31:0] rdata_q;

  // Read sees the pre-write word because both updates are non-blocking.
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[addr];
    for (int k = 0; k < 4; k++) begin
      if (we[k]) begin
        mem_q[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-port responder: byte-writable RAM, MMIO counters/scratch/TOHOST,
// and sticky completion / address-error flags.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_read,
  input  logic [3:0]  data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        sim_done,
  output logic [31:0] done_code,
  output logic        addr_err
);

  localparam int HI_W = 30 - ADDR_WIDTH;

  logic                  ram_hit;
  logic                  mmio_hit;
  logic                  wr_any;
  logic [1:0]            mmio_off;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [3:0]            ram_we;
  logic [31:0]           ram_rdata;
  logic [31:0]           mmio_rdata;
  logic                  unused_addr_bits;

  logic [31:0] cycle_d,     cycle_q;
  logic [31:0] store_cnt_d, store_cnt_q;
  logic [31:0] scratch_d,   scratch_q;
  logic [31:0] done_code_d, done_code_q;
  logic        sim_done_d,  sim_done_q;
  logic        addr_err_d,  addr_err_q;
  logic        from_ram_d,  from_ram_q;
  logic [31:0] out_val_d,   out_val_q;

  assign ram_hit  = (data_addr[31:ADDR_WIDTH+2] == {HI_W{1'b0}});
  assign mmio_hit = (data_addr[31:4] == MMIO_BASE[31:4]);
  assign wr_any   = (data_write != 4'h0);
  assign mmio_off = data_addr[3:2];
  assign ram_idx  = data_addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^data_addr[1:0];

  // RAM writes are gated by decode, completion and reset so the array never
  // changes on a reset edge or after the program has signalled completion.
  always_comb begin
    ram_we = 4'h0;
    if (ram_hit && !sim_done_q && !rst) begin
      ram_we = data_write;
    end else begin
      ram_we = 4'h0;
    end
  end

  bytewrite_sram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_idx),
    .wdata (data_in),
    .rdata (ram_rdata)
  );

  // MMIO read mux uses pre-edge register values (CYCLE before its increment).
  always_comb begin
    mmio_rdata = 32'h0;
    case (mmio_off)
      MMIO_CYCLE:     mmio_rdata = cycle_q;
      MMIO_STORE_CNT: mmio_rdata = store_cnt_q;
      MMIO_TOHOST:    mmio_rdata = done_code_q;
      MMIO_SCRATCH:   mmio_rdata = scratch_q;
      default:        mmio_rdata = 32'h0;
    endcase
  end

  // Next-state for counters, MMIO registers, sticky flags and read-path select.
  always_comb begin
    cycle_d     = cycle_q + 32'd1;
    store_cnt_d = store_cnt_q;
    scratch_d   = scratch_q;
    done_code_d = done_code_q;
    sim_done_d  = sim_done_q;
    addr_err_d  = addr_err_q;
    from_ram_d  = from_ram_q;
    out_val_d   = out_val_q;

    if (wr_any && ram_hit && !sim_done_q) begin
      store_cnt_d = store_cnt_q + 32'd1;
    end else begin
      store_cnt_d = store_cnt_q;
    end

    if (wr_any && mmio_hit && !sim_done_q) begin
      case (mmio_off)
        MMIO_TOHOST: begin
          sim_done_d  = 1'b1;
          done_code_d = merge_bytes(32'h0, data_in, data_write);
        end
        MMIO_SCRATCH: begin
          scratch_d = merge_bytes(scratch_q, data_in, data_write);
        end
        default: begin
          scratch_d = scratch_q;
        end
      endcase
    end else begin
      scratch_d = scratch_q;
    end

    if ((data_read || wr_any) && !ram_hit && !mmio_hit) begin
      addr_err_d = 1'b1;
    end else begin
      addr_err_d = addr_err_q;
    end

    // With no read, freeze the currently presented word in out_val.
    if (data_read) begin
      from_ram_d = ram_hit;
      out_val_d  = mmio_hit ? mmio_rdata : 32'h0;
    end else begin
      from_ram_d = 1'b0;
      out_val_d  = data_out;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q     <= 32'h0;
      store_cnt_q <= 32'h0;
      scratch_q   <= 32'h0;
      done_code_q <= 32'h0;
      sim_done_q  <= 1'b0;
      addr_err_q  <= 1'b0;
      from_ram_q  <= 1'b0;
      out_val_q   <= 32'h0;
    end else begin
      cycle_q     <= cycle_d;
      store_cnt_q <= store_cnt_d;
      scratch_q   <= scratch_d;
      done_code_q <= done_code_d;
      sim_done_q  <= sim_done_d;
      addr_err_q  <= addr_err_d;
      from_ram_q  <= from_ram_d;
      out_val_q   <= out_val_d;
    end
  end

  assign data_out  = from_ram_q ? ram_rdata : out_val_q;
  assign sim_done  = sim_done_q;
  assign done_code = done_code_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder with a behavioural memory/MMIO model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_read = 1'b0;
  logic [3:0]  data_write = 4'h0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        sim_done;
  logic [31:0] done_code;
  logic        addr_err;

  always #5 clk = ~clk;

  data_mem_responder #(
    .ADDR_WIDTH(14),
    .MMIO_BASE (32'hFFFF_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_read (data_read),
    .data_write(data_write),
    .data_addr (data_addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .sim_done  (sim_done),
    .done_code (done_code),
    .addr_err  (addr_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit [31:0] val;
    bit        chk;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state
  bit [31:0]   m_mem [int];
  bit [31:0]   m_store = 32'h0;
  bit [31:0]   m_scratch = 32'h0;
  bit [31:0]   m_code = 32'h0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  bit [31:0]   tb_cycle = 32'h0;

  bit          rd_prev = 1'b0;
  bit          rst_prev = 1'b0;
  bit          last_known = 1'b0;
  bit [31:0]   last_val = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] mrg(input bit [31:0] old_v, input bit [31:0] new_v, input bit [3:0] s);
    bit [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // CYCLE register reference: edges since the last reset edge
  always @(posedge clk) begin
    if (rst) tb_cycle <= 32'h0;
    else     tb_cycle <= tb_cycle + 32'd1;
    rd_prev  <= data_read && !rst;
    rst_prev <= rst;
  end

  // Monitor: pops one expected word per read edge, checks holds otherwise
  always @(negedge clk) begin
    exp_t e;
    if (rst_prev) begin
      check("reset_data_out", data_out, 32'h0);
      last_val   = 32'h0;
      last_known = 1'b1;
    end else if (rd_prev) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        if (e.chk) check("read_data", data_out, e.val);
        last_val   = e.val;
        last_known = e.chk;
      end
    end else if (last_known) begin
      check("hold_data_out", data_out, last_val);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    data_read = 1'b0;
    data_write = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    m_store = 32'h0; m_scratch = 32'h0; m_code = 32'h0;
    m_done = 1'b0; m_err = 1'b0;
    check("reset_sim_done", sim_done, 32'h0);
    check("reset_done_code", done_code, 32'h0);
    check("reset_addr_err", addr_err, 32'h0);
  endtask

  // One access: drive at a negedge, predict, apply model, check sticky outputs.
  task automatic op(input bit rd, input bit [3:0] we, input bit [31:0] addr, input bit [31:0] din);
    exp_t e;
    int   idx;
    bit   ram, mmio;
    data_read = rd; data_write = we; data_addr = addr; data_in = din;
    ram  = (addr < 32'h0001_0000);
    mmio = ((addr & 32'hFFFF_FFF0) == 32'hFFFF_0000);
    idx  = int'(addr[15:2]);
    if (rd) begin
      e.chk = 1'b1;
      e.val = 32'h0;
      if (ram) begin
        if (m_mem.exists(idx)) e.val = m_mem[idx];
        else e.chk = 1'b0;
      end else if (mmio) begin
        case (addr[3:2])
          2'd0: e.val = tb_cycle;
          2'd1: e.val = m_store;
          2'd2: e.val = m_code;
          default: e.val = m_scratch;
        endcase
      end
      sb_q.push_back(e);
    end
    if (we != 4'h0 && !m_done) begin
      if (ram) begin
        if (m_mem.exists(idx)) m_mem[idx] = mrg(m_mem[idx], din, we);
        else if (we == 4'hf) m_mem[idx] = din;
        m_store = m_store + 32'd1;
      end else if (mmio && addr[3:2] == 2'd2) begin
        m_done = 1'b1;
        m_code = mrg(32'h0, din, we);
      end else if (mmio && addr[3:2] == 2'd3) begin
        m_scratch = mrg(m_scratch, din, we);
      end
    end
    if (!ram && !mmio && (rd || we != 4'h0)) m_err = 1'b1;
    @(posedge clk);
    #1;
    check("sim_done", sim_done, m_done);
    check("done_code", done_code, m_code);
    check("addr_err", addr_err, m_err);
    @(negedge clk);
  endtask

  initial begin
    bit [31:0] a;
    int sel;
    do_reset();

    // Full write then readback; STORE_CNT must read 1
    op(1'b0, 4'hf, 32'h0000_0010, 32'hDEADBEEF);
    op(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    op(1'b1, 4'h0, 32'hFFFF_0004, 32'h0);

    for (int i = 0; i < 32; i++) op(1'b0, 4'hf, 32'(i * 4), $urandom);

    // Byte strobes
    op(1'b0, 4'hf, 32'h0000_0020, 32'h11223344);
    op(1'b0, 4'b0101, 32'h0000_0020, 32'hAABBCCDD);
    op(1'b1, 4'h0, 32'h0000_0020, 32'h0);

    // Same-edge read/write is read-first
    op(1'b0, 4'hf, 32'h0000_0030, 32'h0);
    op(1'b1, 4'hf, 32'h0000_0030, 32'h5);
    op(1'b1, 4'h0, 32'h0000_0030, 32'h0);

    // SCRATCH upper-half write
    op(1'b0, 4'b1100, 32'hFFFF_000C, 32'hCAFE0000);
    op(1'b1, 4'h0, 32'hFFFF_000C, 32'h0);

    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6) a = 32'($urandom_range(0, 31) * 4) | 32'($urandom_range(0, 3));
      else if (sel == 7) a = 32'hFFFF_000C;
      else if (sel == 8) a = 32'hFFFF_0000 | 32'($urandom_range(0, 1) * 4);
      else a = 32'($urandom_range(0, 31) * 4);
      op((sel != 9) && ($urandom_range(0, 7) != 0),
         ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, a, $urandom);
    end

    // TOHOST completes the run; later RAM/SCRATCH/TOHOST writes are dropped
    op(1'b1, 4'h0, 32'h0000_0040, 32'h0);
    op(1'b0, 4'hf, 32'hFFFF_0008, 32'h0000_002A);
    op(1'b0, 4'hf, 32'h0000_0040, 32'h99);
    op(1'b1, 4'h0, 32'h0000_0040, 32'h0);
    op(1'b1, 4'h0, 32'hFFFF_0004, 32'h0);
    op(1'b0, 4'hf, 32'hFFFF_000C, 32'h1234_5678);
    op(1'b0, 4'hf, 32'hFFFF_0008, 32'h77);
    op(1'b1, 4'h0, 32'hFFFF_0008, 32'h0);
    op(1'b1, 4'h0, 32'hFFFF_000C, 32'h0);

    // Out-of-range write and read
    op(1'b0, 4'hf, 32'h8000_0000, 32'h55);
    op(1'b1, 4'h0, 32'h8000_0000, 32'h0);
    op(1'b1, 4'h0, 32'h0000_0040, 32'h0);
    op(1'b1, 4'h0, 32'h0001_0000, 32'h0);

    // Reset clears flags; CYCLE read at the 10th edge returns 9
    do_reset();
    for (int i = 0; i < 9; i++) op(1'b0, 4'h0, 32'h0, 32'h0);
    op(1'b1, 4'h0, 32'hFFFF_0000, 32'h0);
    op(1'b1, 4'h0, 32'hFFFF_0004, 32'h0);
    op(1'b1, 4'h0, 32'hFFFF_000C, 32'h0);
    op(1'b1, 4'h0, 32'hFFFF_0008, 32'h0);
    op(1'b0, 4'h0, 32'h0, 32'h0);

    check("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
